// File: rtl/htif_mailbox.sv
// HTIF-style host/target mailbox on APB: the TOHOST_HI write commits a command
// (exit or console putchar), and console bytes drain through a small FIFO.
module htif_mailbox #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        psel,
  input  logic        penable,
  input  logic [11:0] paddr,
  input  logic        pwrite,
  input  logic [3:0]  pstrb,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pslverr,
  output logic        pready,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic        sim_end,
  output logic [31:0] end_code
);

  // state        | meaning
  // S_IDLE       | accepting commands
  // S_WAIT_SPACE | putchar stalled on a full FIFO, pready held low
  // S_DONE       | exit seen; terminal until reset

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] CMD_EXIT = 32'h0000_0000;
  localparam logic [31:0] CMD_PUTC = 32'h0101_0000;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_SPACE, S_DONE} state_t;

  state_t      state, state_n;
  logic [31:0] tohost_lo, tohost_hi, fromhost_lo, fromhost_hi;
  logic        bad_cmd;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic        fifo_full, fifo_empty;
  logic        access, wr_fire, hi_req, addr_ok;
  logic        sel_tlo, sel_thi, sel_flo, sel_fhi, sel_stat;
  logic        push, pop, commit, set_end, set_bad;
  logic [31:0] cmd, status;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? wd[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

  assign sel_tlo  = (paddr == 12'h000);
  assign sel_thi  = (paddr == 12'h004);
  assign sel_flo  = (paddr == 12'h008);
  assign sel_fhi  = (paddr == 12'h00C);
  assign sel_stat = (paddr == 12'h010);
  assign addr_ok  = sel_tlo | sel_thi | sel_flo | sel_fhi | sel_stat;

  assign access  = psel & penable;
  assign wr_fire = access & pwrite & pready;
  assign hi_req  = access & pwrite & sel_thi;
  assign cmd     = merge(tohost_hi, pwdata, pstrb);

  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign char_valid = ~fifo_empty;
  // Head entry is masked while empty so the unreset storage never leaks out.
  assign char_data  = fifo_empty ? 8'h00 : mem[rd_ptr];
  assign pop        = char_valid & char_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    pready  = 1'b1;
    push    = 1'b0;
    commit  = 1'b0;
    set_end = 1'b0;
    set_bad = 1'b0;
    case (state)
      S_IDLE: begin
        if (hi_req) begin
          if (cmd == CMD_EXIT) begin
            set_end = 1'b1;
            commit  = 1'b1;
            state_n = S_DONE;
          end else if (cmd == CMD_PUTC) begin
            if (fifo_full) begin
              pready  = 1'b0;
              state_n = S_WAIT_SPACE;
            end else begin
              push   = 1'b1;
              commit = 1'b1;
            end
          end else begin
            set_bad = 1'b1;
            commit  = 1'b1;
          end
        end
      end
      S_WAIT_SPACE: begin
        if (fifo_full) begin
          pready = 1'b0;
        end else begin
          push    = 1'b1;
          commit  = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_DONE: begin
        if (hi_req) commit = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tohost_lo   <= '0;
      tohost_hi   <= '0;
      fromhost_lo <= '0;
      fromhost_hi <= '0;
      bad_cmd     <= 1'b0;
      sim_end     <= 1'b0;
      end_code    <= '0;
    end else begin
      if (commit) begin
        tohost_lo <= '0;
        tohost_hi <= '0;
      end else begin
        if (wr_fire && sel_tlo) tohost_lo <= merge(tohost_lo, pwdata, pstrb);
        if (wr_fire && sel_thi) tohost_hi <= cmd;
      end
      if (wr_fire && sel_flo) fromhost_lo <= merge(fromhost_lo, pwdata, pstrb);
      if (wr_fire && sel_fhi) fromhost_hi <= merge(fromhost_hi, pwdata, pstrb);
      if (set_bad) bad_cmd <= 1'b1;
      if (set_end) begin
        sim_end  <= 1'b1;
        end_code <= tohost_lo;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tohost_lo[7:0];
  end

  always_comb begin
    status           = '0;
    status[0]        = sim_end;
    status[1]        = fifo_full;
    status[2]        = fifo_empty;
    status[3]        = bad_cmd;
    status[8 +: CW]  = count;
  end

  always_comb begin
    prdata = '0;
    if (access && !pwrite) begin
      case (paddr)
        12'h000: prdata = tohost_lo;
        12'h004: prdata = tohost_hi;
        12'h008: prdata = fromhost_lo;
        12'h00C: prdata = fromhost_hi;
        12'h010: prdata = status;
        default: prdata = '0;
      endcase
    end
  end

  assign pslverr = access & pready & ~addr_ok;

endmodule

// File: tb/tb_htif_mailbox.sv
// Directed bench for htif_mailbox: register map, putchar FIFO, stall, exit, reset.
module tb_htif_mailbox;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [11:0] paddr = '0;
  logic [3:0]  pstrb = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pslverr, pready;
  logic        char_valid, char_ready = 1'b0;
  logic [7:0]  char_data;
  logic        sim_end;
  logic [31:0] end_code;

  int errors = 0;
  int checks = 0;
  logic [31:0] rd;
  logic        er;

  localparam logic [31:0] PUTC = 32'h0101_0000;

  htif_mailbox #(.FIFO_DEPTH(8)) dut (
    .clk(clk), .rstn(rstn), .psel(psel), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pstrb(pstrb), .pwdata(pwdata), .prdata(prdata),
    .pslverr(pslverr), .pready(pready), .char_valid(char_valid),
    .char_data(char_data), .char_ready(char_ready), .sim_end(sim_end),
    .end_code(end_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic [11:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rdat, output logic err);
    int n;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d; pstrb = s;
    @(posedge clk); #1;
    penable = 1'b1;
    #1;
    n = 0;
    while (!pready && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 50) chk("pready_timeout", {31'b0, pready}, 32'h1);
    rdat = prdata;
    err  = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] x;
    logic        e;
    xfer(a, 1'b1, d, s, x, e);
  endtask

  task automatic putc(input logic [7:0] c);
    wr(12'h000, {24'h0, c}, 4'hF);
    wr(12'h004, PUTC, 4'hF);
  endtask

  initial begin
    #23;
    chk("rst_char_valid", {31'b0, char_valid}, 32'h0);
    chk("rst_char_data", {24'b0, char_data}, 32'h0);
    chk("rst_sim_end", {31'b0, sim_end}, 32'h0);
    chk("rst_end_code", end_code, 32'h0);
    chk("rst_pready", {31'b0, pready}, 32'h1);
    chk("rst_prdata", prdata, 32'h0);
    rstn = 1'b1;
    xfer(12'h010, 1'b0, 32'h0, 4'h0, rd, er);
    chk("rst_status", rd, 32'h0000_0004);

    // STATUS writes are ignored without error
    xfer(12'h010, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, er);
    chk("status_wr_err", {31'b0, er}, 32'h0);
    xfer(12'h010, 1'b0, 32'h0, 4'h0, rd, er);
    chk("status_wr_ignored", rd, 32'h0000_0004);

    // byte strobes and FROMHOST storage
    wr(12'h008, 32'h1122_3344, 4'hF);
    wr(12'h008, 32'hAABB_CCDD, 4'h1);
    xfer(12'h008, 1'b0, 32'h0, 4'h0, rd, er);
    chk("fromhost_lo_strb", rd, 32'h1122_33DD);
    wr(12'h00C, 32'hCAFE_F00D, 4'hF);
    wr(12'h00C, 32'h0000_0000, 4'hA);
    xfer(12'h00C, 1'b0, 32'h0, 4'h0, rd, er);
    chk("fromhost_hi_strb", rd, 32'h00FE_000D);

    // single putchar with the consumer ready
    char_ready = 1'b1;
    putc(8'h41);
    chk("putc_valid", {31'b0, char_valid}, 32'h1);
    chk("putc_data", {24'b0, char_data}, 32'h41);
    @(posedge clk); #1;
    chk("putc_popped", {31'b0, char_valid}, 32'h0);
    xfer(12'h000, 1'b0, 32'h0, 4'h0, rd, er);
    chk("tohost_lo_cleared", rd, 32'h0);
    xfer(12'h004, 1'b0, 32'h0, 4'h0, rd, er);
    chk("tohost_hi_cleared", rd, 32'h0);

    // fill the FIFO, then stall the ninth putchar
    char_ready = 1'b0;
    for (int i = 0; i < 8; i++) putc(8'h61 + 8'(i));
    xfer(12'h010, 1'b0, 32'h0, 4'h0, rd, er);
    chk("status_full", rd, 32'h0000_0802);
    wr(12'h000, 32'h69, 4'hF);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 12'h004; pwrite = 1'b1; pwdata = PUTC; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    #1;
    chk("stall_pready_first", {31'b0, pready}, 32'h0);
    repeat (3) begin
      @(posedge clk); #2;
      chk("stall_pready_held", {31'b0, pready}, 32'h0);
    end
    char_ready = 1'b1;
    @(posedge clk); #2;
    char_ready = 1'b0;
    chk("stall_release", {31'b0, pready}, 32'h1);
    chk("head_after_pop", {24'b0, char_data}, 32'h62);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    xfer(12'h010, 1'b0, 32'h0, 4'h0, rd, er);
    chk("status_after_stall", rd, 32'h0000_0802);

    // drain: order preserved across the pointer wrap
    char_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_data", {24'b0, char_data}, 32'h62 + i);
      @(posedge clk); #1;
    end
    chk("drain_empty", {31'b0, char_valid}, 32'h0);
    char_ready = 1'b0;

    // unknown command and bad address
    wr(12'h004, 32'hDEAD_0000, 4'hF);
    xfer(12'h010, 1'b0, 32'h0, 4'h0, rd, er);
    chk("bad_cmd_status", rd, 32'h0000_000C);
    xfer(12'h014, 1'b0, 32'h0, 4'h0, rd, er);
    chk("badaddr_err", {31'b0, er}, 32'h1);
    chk("badaddr_data", rd, 32'h0);
    xfer(12'h020, 1'b1, 32'h1234_5678, 4'hF, rd, er);
    chk("badaddr_wr_err", {31'b0, er}, 32'h1);

    // exit, then a second exit and a putchar are ignored
    wr(12'h000, 32'h1, 4'hF);
    wr(12'h004, 32'h0, 4'hF);
    chk("exit_sim_end", {31'b0, sim_end}, 32'h1);
    chk("exit_code", end_code, 32'h1);
    xfer(12'h010, 1'b0, 32'h0, 4'h0, rd, er);
    chk("exit_status", rd, 32'h0000_000D);
    wr(12'h000, 32'h3, 4'hF);
    wr(12'h004, 32'h0, 4'hF);
    chk("exit_code_kept", end_code, 32'h1);
    xfer(12'h000, 1'b0, 32'h0, 4'h0, rd, er);
    chk("done_lo_cleared", rd, 32'h0);
    putc(8'h55);
    chk("done_no_push", {31'b0, char_valid}, 32'h0);
    xfer(12'h010, 1'b0, 32'h0, 4'h0, rd, er);
    chk("done_status", rd, 32'h0000_000D);

    // reset during a stalled putchar
    #3 rstn = 1'b0;
    #10 rstn = 1'b1;
    chk("rst2_sim_end", {31'b0, sim_end}, 32'h0);
    for (int i = 0; i < 8; i++) putc(8'h30 + 8'(i));
    wr(12'h000, 32'h70, 4'hF);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 12'h004; pwrite = 1'b1; pwdata = PUTC; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #2;
    chk("rst_wait_stalled", {31'b0, pready}, 32'h0);
    rstn = 1'b0;
    #1;
    chk("rst_wait_pready", {31'b0, pready}, 32'h1);
    chk("rst_wait_valid", {31'b0, char_valid}, 32'h0);
    chk("rst_wait_data", {24'b0, char_data}, 32'h0);
    psel = 1'b0; penable = 1'b0;
    #5 rstn = 1'b1;
    xfer(12'h010, 1'b0, 32'h0, 4'h0, rd, er);
    chk("rst_wait_status", rd, 32'h0000_0004);
    chk("rst_wait_no_push", {31'b0, char_valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
